serial_sub2: RTL and testbench

//   Multi-cycle digit-serial subtractor: D = A - B - bin over 2*NDIG-bit operands.

---
 rtl/serial_sub2_if.sv | 39 +++
 rtl/serial_sub2.sv | 96 +++++++++
 tb/tb_serial_sub2.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub2_if.sv
// Request/result bundle for the digit-serial subtractor.
// Ports: in_valid/in_ready/a/b/bin (request), out_valid/out_ready/diff/bout (result),
//        ovf only when SUB_OVF_EN is defined. master = requester/consumer, slave = subtractor.
interface serial_sub2_if #(
  parameter int NDIG = 4
);
  localparam int W = 2 * NDIG;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );
`endif
endinterface

// File: rtl/serial_sub2.sv
// Digit-serial subtractor: diff = a - b - bin mod 2^(2*NDIG), one 2-bit digit per clock, LSD first.
// Latency: out_valid rises NDIG edges after the accepting edge; one result per NDIG+2 cycles.
// Backpressure: result held in DONE until out_ready; no request accepted outside IDLE.
// Ports: clk, rst (sync, active-high), bus (serial_sub2_if.slave).
// Optional: define SUB_OVF_EN to add the signed-overflow flag bus.ovf.
module serial_sub2 #(
  parameter int NDIG = 4
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub2_if.slave  bus
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cnt;
  logic                   br;
  logic [NDIG-1:0][1:0]   a_dig;
  logic [NDIG-1:0][1:0]   b_dig;
  logic [NDIG-1:0][1:0]   diff_dig;
  logic                   bout_r;
  logic [2:0]             dsub;
  logic                   last;

  // 3-bit two's-complement digit subtract: range -4..3, so bit 2 is exactly the borrow.
  assign dsub = {1'b0, a_dig[cnt]} - {1'b0, b_dig[cnt]} - {2'b00, br};
  assign last = (cnt == CW'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_dig;
  assign bus.bout      = bout_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dig    <= '0;
      b_dig    <= '0;
      diff_dig <= '0;
      br       <= 1'b0;
      bout_r   <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_dig <= bus.a;
            b_dig <= bus.b;
            br    <= bus.bin;
            cnt   <= '0;
          end
        end
        RUN: begin
          diff_dig[cnt] <= dsub[1:0];
          br            <= dsub[2];
          cnt           <= cnt + CW'(1);
          if (last) bout_r <= dsub[2];
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_r;

  assign bus.ovf = ovf_r;

  // Evaluated on the last RUN edge, where dsub[1] is the final diff MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_r <= (a_dig[NDIG-1][1] != b_dig[NDIG-1][1]) && (dsub[1] != a_dig[NDIG-1][1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub2.sv
// Directed bench for serial_sub2: NDIG=4 instance for the main tests, NDIG=1 instance for the
// exhaustive digit sweep. Inputs change after the rising edge, outputs sampled on the falling edge.
module tb_serial_sub2;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_sub2_if #(.NDIG(4)) if4 ();
  serial_sub2_if #(.NDIG(1)) if1 ();

  serial_sub2 #(.NDIG(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_sub2 #(.NDIG(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request into the NDIG=4 instance, returns result and accept-to-valid edge count,
  // then completes the result handshake.
  task automatic op4(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     output logic [7:0] d, output logic bo, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!if4.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if4.a = av; if4.b = bv; if4.bin = bi; if4.in_valid = 1'b1;
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!if4.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d  = if4.diff;
    bo = if4.bout;
    if4.out_ready = 1'b1;
    @(posedge clk);
    #1 if4.out_ready = 1'b0;
  endtask

  task automatic op1(input logic [1:0] av, input logic [1:0] bv, input logic bi,
                     output logic [1:0] d, output logic bo, output int lat);
    @(negedge clk);
    if1.a = av; if1.b = bv; if1.bin = bi; if1.in_valid = 1'b1;
    @(posedge clk);
    #1 if1.in_valid = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!if1.out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d  = if1.diff;
    bo = if1.bout;
    if1.out_ready = 1'b1;
    @(posedge clk);
    #1 if1.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if4.in_ready, if4.out_valid, if4.diff, if4.bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset4: got rdy=%b vld=%b diff=%h bout=%b, want 1 0 00 0",
               if4.in_ready, if4.out_valid, if4.diff, if4.bout);
    end
    checks++;
    if ({if1.in_ready, if1.out_valid, if1.diff, if1.bout} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset1: got rdy=%b vld=%b diff=%h bout=%b, want 1 0 0 0",
               if1.in_ready, if1.out_valid, if1.diff, if1.bout);
    end
`ifdef SUB_OVF_EN
    checks++;
    if (if4.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", if4.ovf);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic bo; int lat;
    op4(8'h00, 8'h01, 1'b0, d, bo, lat);
    checks++;
    if ({d, bo} !== {8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL wrap: got diff=%h bout=%b want FF 1", d, bo);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency: got %0d edges want 4", lat);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] av [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h7F};
    logic [7:0] bv [4] = '{8'h5A, 8'h3C, 8'h00, 8'h80};
    logic       bi [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ed [4] = '{8'h4A, 8'hFF, 8'hFF, 8'hFF};
    logic       eb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d; logic bo; int lat;
    for (int i = 0; i < 4; i++) begin
      op4(av[i], bv[i], bi[i], d, bo, lat);
      checks++;
      if ({d, bo} !== {ed[i], eb[i]}) begin
        errors++;
        $display("FAIL vec%0d: got diff=%h bout=%b want %h %b", i, d, bo, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_ndig1_sweep();
    logic [1:0] d; logic bo; int lat;
    int exp_d; logic exp_b;
    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        for (int bi = 0; bi < 2; bi++) begin
          op1(2'(av), 2'(bv), 1'(bi), d, bo, lat);
          exp_d = (av - bv - bi) & 3;
          exp_b = (av < bv + bi);
          checks++;
          if (d !== 2'(exp_d) || bo !== exp_b || lat !== 1) begin
            errors++;
            $display("FAIL sweep a=%0d b=%0d bin=%0d: got diff=%0d bout=%b lat=%0d want %0d %b 1",
                     av, bv, bi, d, bo, lat, exp_d, exp_b);
          end
        end
      end
    end
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    if4.a = 8'h55; if4.b = 8'h11; if4.bin = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!if4.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      if4.in_valid = i[0];
      if4.a = 8'(i);
      @(negedge clk);
      checks++;
      if ({if4.out_valid, if4.in_ready, if4.diff, if4.bout} !== {1'b1, 1'b0, 8'h44, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d: got vld=%b rdy=%b diff=%h bout=%b want 1 0 44 0",
                 i, if4.out_valid, if4.in_ready, if4.diff, if4.bout);
      end
    end
    // Result handshake with a request present in the same cycle: only the handshake completes.
    if4.in_valid = 1'b1;
    if4.out_ready = 1'b1;
    @(posedge clk);
    #1 if4.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({if4.in_ready, if4.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL release: got rdy=%b vld=%b want 1 0", if4.in_ready, if4.out_valid);
    end
    if4.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d; logic bo; int lat;
    @(negedge clk);
    if4.a = 8'hFF; if4.b = 8'h00; if4.bin = 1'b0; if4.in_valid = 1'b1;
    @(posedge clk);
    #1 if4.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if4.in_ready, if4.out_valid, if4.diff, if4.bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL abort: got rdy=%b vld=%b diff=%h bout=%b want 1 0 00 0",
               if4.in_ready, if4.out_valid, if4.diff, if4.bout);
    end
    op4(8'h10, 8'h01, 1'b0, d, bo, lat);
    checks++;
    if ({d, bo} !== {8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL after_abort: got diff=%h bout=%b want 0F 0", d, bo);
    end
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf();
    logic [7:0] d; logic bo; int lat;
    op4(8'h80, 8'h01, 1'b0, d, bo, lat);
    checks++;
    if ({d, if4.ovf} !== {8'h7F, 1'b1}) begin
      errors++;
      $display("FAIL ovf1: got diff=%h ovf=%b want 7F 1", d, if4.ovf);
    end
    op4(8'h10, 8'h01, 1'b0, d, bo, lat);
    checks++;
    if ({d, if4.ovf} !== {8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL ovf0: got diff=%h ovf=%b want 0F 0", d, if4.ovf);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    test_reset();
    test_wrap();
    test_vectors();
    test_ndig1_sweep();
    test_hold();
    test_reset_mid_run();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
